// File: rtl/riscv_core_dcache_pkg.sv
// riscv_core_dcache_pkg: shared types and constants for the dcache memory responder.
// Contents: FSM state enum, block geometry (32-byte blocks, 5-bit offset),
// doubleword-select position/width and write-strobe width.
package riscv_core_dcache_pkg;
    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;
    localparam int BLOCK_BYTES = 32;
    localparam int BLK_OFF_W   = 5;
    localparam int DW_SEL_LSB  = 3;
    localparam int DW_SEL_W    = 2;
    localparam int STRB_W      = 8;
endpackage

// File: rtl/riscv_core_dcache_mem_array.sv
// riscv_core_dcache_mem_array: block-organised backing store for the dcache memory responder.
// Ports: i_clk/i_rst_n clock and async active-low reset (read register only, store not reset);
// i_rd_en/i_rd_idx/i_rd_zero load o_rd_data with a whole block (or zeros) on the clock edge;
// i_wr_en/i_wr_idx/i_wr_sel/i_wr_data/i_wr_strb byte-strobed write of one doubleword in a block.
module riscv_core_dcache_mem_array
    import riscv_core_dcache_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int DATA_W  = 256,
    parameter int WORD_W  = 64,
    parameter int IDX_W   = $clog2(DEPTH)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_rd_en,
    input  logic                i_rd_zero,
    input  logic [IDX_W-1:0]    i_rd_idx,
    output logic [DATA_W-1:0]   o_rd_data,
    input  logic                i_wr_en,
    input  logic [IDX_W-1:0]    i_wr_idx,
    input  logic [DW_SEL_W-1:0] i_wr_sel,
    input  logic [WORD_W-1:0]   i_wr_data,
    input  logic [STRB_W-1:0]   i_wr_strb
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en)
            for (int b = 0; b < STRB_W; b++)
                if (i_wr_strb[b])
                    mem[i_wr_idx][i_wr_sel*WORD_W + b*8 +: 8] <= i_wr_data[b*8 +: 8];
    end

    // The read register doubles as the refill output, so it holds between reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_rd_data <= '0;
        else if (i_rd_en)
            o_rd_data <= i_rd_zero ? '0 : mem[i_rd_idx];
    end
endmodule

// File: rtl/riscv_core_dcache_mem_responder.sv
// riscv_core_dcache_mem_responder: fixed-latency backing memory behind the dcache refill/write-through port.
// Ports: i_clk, i_rst_n (async active-low); read channel i_mem_read_req/i_mem_read_address ->
// o_mem_read_done/o_mem_read_data (256-bit block); write channel i_mem_write_valid/_data/_address/_strobe
// -> o_mem_write_done; o_busy high while not IDLE.
// Optional macro DCACHE_MEM_RESP_RANGE_CHECK_EN adds o_mem_resp_err for addresses beyond the store.
module riscv_core_dcache_mem_responder
    import riscv_core_dcache_pkg::*;
#(
    parameter int ADDR_WIDTH       = 64,
    parameter int CORE_DATA_WIDTH  = 64,
    parameter int AXI_DATA_WIDTH   = 256,
    parameter int MEM_DEPTH_BLOCKS = 1024,
    parameter int READ_LATENCY     = 4,
    parameter int WRITE_LATENCY    = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]      i_mem_read_address,
    output logic                       o_mem_read_done,
    output logic [AXI_DATA_WIDTH-1:0]  o_mem_read_data,
    input  logic                       i_mem_write_valid,
    input  logic [CORE_DATA_WIDTH-1:0] i_mem_write_data,
    input  logic [ADDR_WIDTH-1:0]      i_mem_write_address,
    input  logic [STRB_W-1:0]          i_mem_write_strobe,
    output logic                       o_mem_write_done,
    output logic                       o_busy
`ifdef DCACHE_MEM_RESP_RANGE_CHECK_EN
    ,
    output logic                       o_mem_resp_err
`endif
);
    localparam int IDX_W   = $clog2(MEM_DEPTH_BLOCKS);
    localparam int MAX_LAT = READ_LATENCY > WRITE_LATENCY ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic [ADDR_WIDTH-1:0]      cap_addr;
    logic [CORE_DATA_WIDTH-1:0] cap_data;
    logic [STRB_W-1:0]          cap_strb;
    logic                       in_idle;
    logic                       rd_fire;
    logic                       wr_fire;
    logic                       err_now;
    logic [ADDR_WIDTH-1:0]      addr_now;
    logic [CORE_DATA_WIDTH-1:0] data_now;
    logic [STRB_W-1:0]          strb_now;
    logic                       unused_ok;

    // In IDLE the request comes straight from the ports so that a latency of 1
    // can complete on the acceptance edge; otherwise the captured copy is used.
    assign in_idle  = state == IDLE;
    assign addr_now = in_idle ? (i_mem_write_valid ? i_mem_write_address : i_mem_read_address) : cap_addr;
    assign data_now = in_idle ? i_mem_write_data : cap_data;
    assign strb_now = in_idle ? i_mem_write_strobe : cap_strb;

    // Completion edge: counter about to reach 0 with the request still held.
    assign rd_fire = (in_idle && !i_mem_write_valid && i_mem_read_req && READ_LATENCY == 1)
                   || (state == RD_WAIT && i_mem_read_req && cnt == CNT_W'(1));
    assign wr_fire = (in_idle && i_mem_write_valid && WRITE_LATENCY == 1)
                   || (state == WR_WAIT && i_mem_write_valid && cnt == CNT_W'(1));

`ifdef DCACHE_MEM_RESP_RANGE_CHECK_EN
    assign err_now = |addr_now[ADDR_WIDTH-1:BLK_OFF_W+IDX_W];
`else
    assign err_now = 1'b0;
`endif
    assign unused_ok = &{1'b0, addr_now[ADDR_WIDTH-1:BLK_OFF_W+IDX_W], addr_now[DW_SEL_LSB-1:0]};

    riscv_core_dcache_mem_array #(
        .DEPTH  (MEM_DEPTH_BLOCKS),
        .DATA_W (AXI_DATA_WIDTH),
        .WORD_W (CORE_DATA_WIDTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_rd_en   (rd_fire),
        .i_rd_zero (err_now),
        .i_rd_idx  (addr_now[BLK_OFF_W +: IDX_W]),
        .o_rd_data (o_mem_read_data),
        .i_wr_en   (wr_fire && !err_now),
        .i_wr_idx  (addr_now[BLK_OFF_W +: IDX_W]),
        .i_wr_sel  (addr_now[DW_SEL_LSB +: DW_SEL_W]),
        .i_wr_data (data_now),
        .i_wr_strb (strb_now)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            cap_addr         <= '0;
            cap_data         <= '0;
            cap_strb         <= '0;
            o_mem_read_done  <= 1'b0;
            o_mem_write_done <= 1'b0;
            o_busy           <= 1'b0;
        end else begin
            o_mem_read_done  <= rd_fire;
            o_mem_write_done <= wr_fire;
            case (state)
                IDLE: begin
                    if (i_mem_write_valid) begin
                        cap_addr <= i_mem_write_address;
                        cap_data <= i_mem_write_data;
                        cap_strb <= i_mem_write_strobe;
                        cnt      <= CNT_W'(WRITE_LATENCY - 1);
                        state    <= WRITE_LATENCY == 1 ? WR_DONE : WR_WAIT;
                        o_busy   <= 1'b1;
                    end else if (i_mem_read_req) begin
                        cap_addr <= i_mem_read_address;
                        cnt      <= CNT_W'(READ_LATENCY - 1);
                        state    <= READ_LATENCY == 1 ? RD_DONE : RD_WAIT;
                        o_busy   <= 1'b1;
                    end
                end
                RD_WAIT: begin
                    if (!i_mem_read_req) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= RD_DONE;
                    end
                end
                WR_WAIT: begin
                    if (!i_mem_write_valid) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1))
                            state <= WR_DONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_MEM_RESP_RANGE_CHECK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_mem_resp_err <= 1'b0;
        else
            o_mem_resp_err <= (rd_fire || wr_fire) && err_now;
    end
`endif
endmodule

// File: tb/tb_riscv_core_dcache_mem_responder.sv
// tb_riscv_core_dcache_mem_responder: directed self-checking bench for the dcache memory responder.
module tb_riscv_core_dcache_mem_responder;
    localparam int RL = 4;
    localparam int WL = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rd_req = 1'b0;
    logic [63:0]  rd_addr = '0;
    logic         rd_done;
    logic [255:0] rd_data;
    logic         wr_valid = 1'b0;
    logic [63:0]  wr_data = '0;
    logic [63:0]  wr_addr = '0;
    logic [7:0]   wr_strb = '0;
    logic         wr_done;
    logic         busy;
    logic         resp_err;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           done_cyc = 0;
    logic         err_seen = 1'b0;
    logic [255:0] exp2;
    logic [255:0] exp3;
    logic [255:0] d;
    logic [63:0]  p;
    int           lat;
    int           t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_core_dcache_mem_responder dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_mem_read_req      (rd_req),
        .i_mem_read_address  (rd_addr),
        .o_mem_read_done     (rd_done),
        .o_mem_read_data     (rd_data),
        .i_mem_write_valid   (wr_valid),
        .i_mem_write_data    (wr_data),
        .i_mem_write_address (wr_addr),
        .i_mem_write_strobe  (wr_strb),
        .o_mem_write_done    (wr_done),
        .o_busy              (busy)
`ifdef DCACHE_MEM_RESP_RANGE_CHECK_EN
        ,
        .o_mem_resp_err      (resp_err)
`endif
    );
`ifndef DCACHE_MEM_RESP_RANGE_CHECK_EN
    assign resp_err = 1'b0;
`endif

    function automatic logic [63:0] pat(input int b, input int k);
        return (64'(b) << 56) | (64'(k) << 48) | 64'h0000_1234_5678_9ABC;
    endfunction

    function automatic logic [255:0] blk(input int b);
        logic [255:0] r;
        for (int k = 0; k < 4; k++) r[64*k +: 64] = pat(b, k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [63:0] a, output logic [255:0] dat, output int l);
        rd_addr = a;
        rd_req = 1'b1;
        l = 0;
        do begin tick(); l++; end while (!rd_done && l < 20);
        dat = rd_data;
        err_seen = resp_err;
        done_cyc = cyc;
        rd_req = 1'b0;
        tick();
        chk("rd_pulse_one_cycle", rd_done, 0);
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] wd, input logic [7:0] s, output int l);
        wr_addr = a;
        wr_data = wd;
        wr_strb = s;
        wr_valid = 1'b1;
        l = 0;
        do begin tick(); l++; end while (!wr_done && l < 20);
        err_seen = resp_err;
        wr_valid = 1'b0;
        tick();
        chk("wr_pulse_one_cycle", wr_done, 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_rd_done", rd_done, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();
        // Preload blocks 2 and 3 through the write port.
        for (int k = 0; k < 4; k++) begin
            do_write(64'h40 + 64'(8*k), pat(2, k), 8'hFF, lat);
            chk("fill2_lat", lat, WL);
            do_write(64'h60 + 64'(8*k), pat(3, k), 8'hFF, lat);
            chk("fill3_lat", lat, WL);
        end
        exp2 = blk(2);
        exp3 = blk(3);
        // Cycle-exact read of block 3.
        rd_addr = 64'h60;
        rd_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("t1_done", rd_done, i == 4);
            chk("t1_busy", busy, i <= 4);
            if (i == 4) begin
                chk("t1_data", rd_data, exp3);
                rd_req = 1'b0;
            end
        end
        // Partial-strobe write to doubleword 1 of block 2.
        do_write(64'h48, 64'h1122334455667788, 8'h0F, lat);
        chk("t2_wr_lat", lat, WL);
        p = pat(2, 1);
        exp2[64 +: 64] = {p[63:32], 32'h55667788};
        do_read(64'h40, d, lat);
        chk("t2_rd_lat", lat, RL);
        chk("t2_data", d, exp2);
        // Zero strobe completes but changes nothing.
        do_write(64'h68, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, lat);
        chk("strb0_lat", lat, WL);
        do_read(64'h60, d, lat);
        chk("strb0_data", d, exp3);
        // Simultaneous requests: write wins, read follows and sees it.
        wr_addr = 64'h50;
        wr_data = 64'hDEAD_BEEF_0BAD_F00D;
        wr_strb = 8'hFF;
        wr_valid = 1'b1;
        rd_addr = 64'h40;
        rd_req = 1'b1;
        tick();
        chk("t3_c1_wr_done", wr_done, 0);
        chk("t3_c1_rd_done", rd_done, 0);
        tick();
        chk("t3_c2_wr_done", wr_done, 1);
        chk("t3_c2_rd_done", rd_done, 0);
        wr_valid = 1'b0;
        tick();
        chk("t3_c3_rd_done", rd_done, 0);
        exp2[128 +: 64] = 64'hDEAD_BEEF_0BAD_F00D;
        do_read(64'h40, d, lat);
        chk("t3_rd_lat", lat, RL);
        chk("t3_data", d, exp2);
        // Read aborted in cycle 2.
        rd_addr = 64'hC0;
        rd_req = 1'b1;
        tick();
        tick();
        chk("t4_busy_c2", busy, 1);
        rd_req = 1'b0;
        tick();
        chk("t4_busy_c3", busy, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_done", rd_done, 0);
            tick();
        end
        chk("t4_data_held", rd_data, exp2);
        // Reset during WR_WAIT discards the write.
        wr_addr = 64'h60;
        wr_data = 64'h0;
        wr_strb = 8'hFF;
        wr_valid = 1'b1;
        tick();
        chk("t5_busy_wait", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_wr_done_rst", wr_done, 0);
        chk("t5_rd_data_rst", rd_data, 0);
        wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_read(64'h60, d, lat);
        chk("t5_rd_lat", lat, RL);
        chk("t5_unmodified", d, exp3);
        // Back-to-back reads.
        do_read(64'h40, d, lat);
        t0 = done_cyc;
        do_read(64'h60, d, lat);
        chk("t6_spacing", done_cyc - t0, RL + 1);
        chk("t6_data", d, exp3);
`ifdef DCACHE_MEM_RESP_RANGE_CHECK_EN
        do_read(64'h1_0000_0060, d, lat);
        chk("err_rd_lat", lat, RL);
        chk("err_rd_flag", err_seen, 1);
        chk("err_rd_data", d, 0);
        do_write(64'h1_0000_0068, 64'h0, 8'hFF, lat);
        chk("err_wr_lat", lat, WL);
        chk("err_wr_flag", err_seen, 1);
        do_read(64'h60, d, lat);
        chk("err_ok_flag", err_seen, 0);
        chk("err_wr_no_update", d, exp3);
`else
        do_read(64'h8060, d, lat);
        chk("alias_lat", lat, RL);
        chk("alias_data", d, exp3);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
